// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell, LSB first, WIDTH cycles per op.
// Operands and result move over valid/ready handshakes; flags are captured at completion.

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             busy
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic fa_sum;
  logic fa_cout;
  logic last_bit;

  full_adder u_fa (
    .a_i(a_q[0]),
    .b_i(b_q[0]),
    .c_i(carry_q),
    .s_o(fa_sum),
    .c_o(fa_cout)
  );

  assign last_bit = (cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_sub ? ~op_b : op_b;
          carry_d = op_sub;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sh_d            = sh_q >> 1;
        sh_d[WIDTH-1]   = fa_sum;
        a_d             = a_q >> 1;
        b_d             = b_q >> 1;
        carry_d         = fa_cout;
        cnt_d           = cnt_q + CntW'(1);
        if (last_bit) begin
          // carry_q here is the carry into the MSB; flags live in their own regs so they
          // survive the next accept unchanged until the following completion.
          res_d   = sh_d;
          cout_d  = fa_cout;
          ovf_d   = carry_q ^ fa_cout;
          zero_d  = (sh_d == '0);
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  // Handshake outputs decode registered state only.
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign result    = res_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8: vector table plus backpressure,
// ignored-input and mid-operation reset sequences.

module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         op_sub;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         zero;
  logic         busy;

  int errors = 0;
  int checks = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_sub   (op_sub),
    .op_a     (op_a),
    .op_b     (op_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .carry_out(carry_out),
    .overflow (overflow),
    .zero     (zero),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Starts at a negedge with the DUT idle; returns edges from accept to out_valid.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        output int lat);
    op_a     = a;
    op_b     = b;
    op_sub   = sub;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_op(input string name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_ovalid_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    int bad;
    logic [W-1:0] r0;

    vecs[0] = '{a: 8'h7F, b: 8'h01, sub: 1'b0, res: 8'h80, c: 1'b0, v: 1'b1, z: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, sub: 1'b0, res: 8'h00, c: 1'b1, v: 1'b0, z: 1'b1};
    vecs[2] = '{a: 8'h05, b: 8'h07, sub: 1'b1, res: 8'hFE, c: 1'b0, v: 1'b0, z: 1'b0};
    vecs[3] = '{a: 8'h10, b: 8'h10, sub: 1'b1, res: 8'h00, c: 1'b1, v: 1'b0, z: 1'b1};
    vecs[4] = '{a: 8'h80, b: 8'h01, sub: 1'b1, res: 8'h7F, c: 1'b1, v: 1'b1, z: 1'b0};
    vecs[5] = '{a: 8'h03, b: 8'h04, sub: 1'b0, res: 8'h07, c: 1'b0, v: 1'b0, z: 1'b0};
    vecs[6] = '{a: 8'h55, b: 8'hAA, sub: 1'b0, res: 8'hFF, c: 1'b0, v: 1'b0, z: 1'b0};
    vecs[7] = '{a: 8'h01, b: 8'h02, sub: 1'b1, res: 8'hFF, c: 1'b0, v: 1'b0, z: 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    op_sub    = 1'b0;
    op_a      = '0;
    op_b      = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flags", {29'd0, carry_out, overflow, zero}, 32'd0);

    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== '0) bad++;
    end
    check("idle_stable_bad_cycles", 32'(bad), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(W));
      check($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].res));
      check($sformatf("v%0d_carry", i), 32'(carry_out), 32'(vecs[i].c));
      check($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].v));
      check($sformatf("v%0d_zero", i), 32'(zero), 32'(vecs[i].z));
      finish_op($sformatf("v%0d", i));
    end

    // Backpressure with in_valid toggling on junk operands throughout RUN and DONE.
    op_a     = 8'h7F;
    op_b     = 8'h01;
    op_sub   = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    bad = 0;
    for (int k = 1; k <= 8; k++) begin
      in_valid = ~in_valid;
      op_a     = 8'hFF;
      op_b     = 8'hFF;
      op_sub   = 1'b1;
      if (in_ready !== 1'b0 || busy !== 1'b1) bad++;
      @(negedge clk);
    end
    check("bp_run_ready_low", 32'(bad), 32'd0);
    check("bp_ovalid_at_8", 32'(out_valid), 32'd1);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      in_valid = ~in_valid;
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 8'h80 || carry_out !== 1'b0 ||
          overflow !== 1'b1 || zero !== 1'b0) bad++;
    end
    check("bp_hold_bad_cycles", 32'(bad), 32'd0);
    check("bp_result", 32'(result), 32'h80);
    check("bp_overflow", 32'(overflow), 32'd1);
    in_valid = 1'b0;
    finish_op("bp");
    check("bp_idle_busy", 32'(busy), 32'd0);
    r0 = result;
    @(negedge clk);
    check("bp_idle_result_held", 32'(result), 32'h80);
    check("bp_idle_result_stable", 32'(result), 32'(r0));
    check("bp_nothing_accepted", 32'(busy), 32'd0);

    // Reset with the bit counter at 3.
    op_a     = 8'h12;
    op_b     = 8'h34;
    op_sub   = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_in_ready", 32'(in_ready), 32'd1);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_out_valid", 32'(out_valid), 32'd0);
    check("mid_result", 32'(result), 32'd0);
    check("mid_flags", {29'd0, carry_out, overflow, zero}, 32'd0);
    run_op(8'h03, 8'h04, 1'b0, lat);
    check("post_rst_latency", 32'(lat), 32'(W));
    check("post_rst_result", 32'(result), 32'h07);
    check("post_rst_flags", {29'd0, carry_out, overflow, zero}, 32'd0);
    finish_op("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
